// File: rtl/joy_test_monitor.sv
// Joystick capture for the board test screen: sync, debounce, seen history,
// per-channel done flags, saturating press counters and a user-button mode toggle.
module joy_test_monitor #(
  parameter int              NJOY       = 2,
  parameter int              JW         = 16,
  parameter int              DEB_CYCLES = 7000,
  parameter int              CNTW       = 8,
  parameter logic [JW-1:0]   DONE_MASK  = 16'h0FFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NJOY*JW-1:0]   joy_in,
  input  logic                 btn_user,
  input  logic                 clear,
  output logic [NJOY*JW-1:0]   joy_stable,
  output logic [NJOY*JW-1:0]   joy_seen,
  output logic [NJOY-1:0]      joy_done,
  output logic [NJOY*CNTW-1:0] press_count,
  output logic                 mode,
  output logic                 sample_tick
);

  localparam int NB = NJOY * JW;
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = $clog2(JW + 1);
  localparam int SW = CNTW + PW;
  localparam logic [CNTW-1:0] CMAX = {CNTW{1'b1}};

  function automatic logic [PW-1:0] popcount(input logic [JW-1:0] v);
    logic [PW-1:0] n;
    n = {PW{1'b0}};
    for (int i = 0; i < JW; i++) begin
      n = n + PW'(v[i]);
    end
    return n;
  endfunction

  // The user button rides along as the top bit so it shares sync and debounce.
  logic [NB:0]          raw_s;
  logic [NB:0]          meta_r;
  logic [NB:0]          sync_r;
  logic [NB:0]          hist0_r;
  logic [NB:0]          hist1_r;
  logic [NB:0]          hist2_r;
  logic [NB:0]          stable_r;
  logic [NB:0]          stable_d_r;
  logic [NB:0]          rise_s;
  logic [NB:0]          all_one_s;
  logic [NB:0]          all_zero_s;
  logic [CW-1:0]        cnt_r;
  logic                 tick_r;
  logic [NB-1:0]        seen_r;
  logic [NJOY-1:0]      done_r;
  logic [NJOY*CNTW-1:0] count_r;
  logic [NJOY*CNTW-1:0] count_next_s;
  logic                 mode_r;

  assign raw_s      = {btn_user, joy_in};
  assign all_one_s  = hist0_r & hist1_r & hist2_r;
  assign all_zero_s = ~(hist0_r | hist1_r | hist2_r);
  assign rise_s     = stable_r & ~stable_d_r;

  // Two-flop synchronisers, debounce prescaler and 3-sample histories.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r     <= {(NB+1){1'b0}};
      sync_r     <= {(NB+1){1'b0}};
      hist0_r    <= {(NB+1){1'b0}};
      hist1_r    <= {(NB+1){1'b0}};
      hist2_r    <= {(NB+1){1'b0}};
      stable_r   <= {(NB+1){1'b0}};
      stable_d_r <= {(NB+1){1'b0}};
      cnt_r      <= {CW{1'b0}};
      tick_r     <= 1'b0;
    end else begin
      meta_r     <= raw_s;
      sync_r     <= meta_r;
      stable_d_r <= stable_r;
      stable_r   <= all_one_s | (stable_r & ~all_zero_s);
      if (cnt_r == CW'(DEB_CYCLES - 1)) begin
        cnt_r  <= {CW{1'b0}};
        tick_r <= 1'b1;
      end else begin
        cnt_r  <= cnt_r + CW'(1);
        tick_r <= 1'b0;
      end
      if (tick_r) begin
        hist2_r <= hist1_r;
        hist1_r <= hist0_r;
        hist0_r <= sync_r;
      end
    end
  end

  // Saturating add of this cycle's rising edges to each channel counter.
  always_comb begin
    count_next_s = count_r;
    for (int j = 0; j < NJOY; j++) begin
      logic [SW-1:0] sum_v;
      sum_v = {{PW{1'b0}}, count_r[j*CNTW +: CNTW]} +
              {{CNTW{1'b0}}, popcount(rise_s[j*JW +: JW])};
      if (sum_v > {{PW{1'b0}}, CMAX}) begin
        count_next_s[j*CNTW +: CNTW] = CMAX;
      end else begin
        count_next_s[j*CNTW +: CNTW] = sum_v[CNTW-1:0];
      end
    end
  end

  // Seen history, counters, done flags and mode; clear overrides same-cycle rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_r  <= {NB{1'b0}};
      count_r <= {(NJOY*CNTW){1'b0}};
      done_r  <= {NJOY{1'b0}};
      mode_r  <= 1'b0;
    end else begin
      if (clear) begin
        seen_r  <= {NB{1'b0}};
        count_r <= {(NJOY*CNTW){1'b0}};
      end else begin
        seen_r  <= seen_r | rise_s[NB-1:0];
        count_r <= count_next_s;
      end
      for (int j = 0; j < NJOY; j++) begin
        done_r[j] <= ((seen_r[j*JW +: JW] & DONE_MASK) == DONE_MASK);
      end
      if (rise_s[NB]) begin
        mode_r <= ~mode_r;
      end else begin
        mode_r <= mode_r;
      end
    end
  end

  assign joy_stable  = stable_r[NB-1:0];
  assign joy_seen    = seen_r;
  assign joy_done    = done_r;
  assign press_count = count_r;
  assign mode        = mode_r;
  assign sample_tick = tick_r;

endmodule

// File: tb/tb_joy_test_monitor.sv
// Directed bench for joy_test_monitor with a short debounce period.
module tb_joy_test_monitor;

  localparam int NJOY = 2;
  localparam int JW   = 16;
  localparam int DEB  = 4;
  localparam int CNTW = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NJOY*JW-1:0]   joy_in;
  logic                 btn_user;
  logic                 clear;
  logic [NJOY*JW-1:0]   joy_stable;
  logic [NJOY*JW-1:0]   joy_seen;
  logic [NJOY-1:0]      joy_done;
  logic [NJOY*CNTW-1:0] press_count;
  logic                 mode;
  logic                 sample_tick;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_hit;

  joy_test_monitor #(
    .NJOY(NJOY), .JW(JW), .DEB_CYCLES(DEB), .CNTW(CNTW), .DONE_MASK(16'h000F)
  ) dut (
    .clk(clk), .rst(rst), .joy_in(joy_in), .btn_user(btn_user), .clear(clear),
    .joy_stable(joy_stable), .joy_seen(joy_seen), .joy_done(joy_done),
    .press_count(press_count), .mode(mode), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    joy_in   = '0;
    btn_user = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    step(3);
    rst = 1'b0;
    cyc = 0;

    check("rst_stable", joy_stable, 64'd0);
    check("rst_seen", joy_seen, 64'd0);
    check("rst_misc", {joy_done, press_count, mode, sample_tick}, 64'd0);

    // idle: tick every 4 cycles, first at cycle 4
    for (int k = 1; k <= 50; k++) begin
      step(1);
      check("idle_tick", sample_tick, (cyc % DEB == 0) ? 64'd1 : 64'd0);
      check("idle_stable", joy_stable, 64'd0);
      check("idle_seen", joy_seen, 64'd0);
      check("idle_misc", {joy_done, press_count, mode}, 64'd0);
    end

    // channel 0 bit 0 driven at cycle 50 -> stable at 62, seen/count at 63
    joy_in[0] = 1'b1;
    t_hit = -1;
    for (int k = 0; k < 30 && t_hit < 0; k++) begin
      step(1);
      if (joy_stable[0] === 1'b1) t_hit = cyc;
    end
    check("b0_stable_cycle", t_hit, 64'd62);
    check("b0_seen_pre", joy_seen[15:0], 64'd0);
    check("b0_cnt_pre", press_count[3:0], 64'd0);
    step(1);
    check("b0_seen", joy_seen[15:0], 64'h0001);
    check("b0_cnt", press_count[3:0], 64'd1);
    check("b0_done", joy_done, 64'd0);
    step(5);
    check("b0_cnt_hold", press_count[3:0], 64'd1);

    // short glitch on channel 1 bit 2
    joy_in[18] = 1'b1;
    step(6);
    joy_in[18] = 1'b0;
    step(30);
    check("glitch_stable", joy_stable[31:16], 64'd0);
    check("glitch_seen", joy_seen[31:16], 64'd0);
    check("glitch_cnt", press_count[7:4], 64'd0);

    // bits 1..3 together
    joy_in[15:0] = 16'h000F;
    t_hit = -1;
    for (int k = 0; k < 30 && t_hit < 0; k++) begin
      step(1);
      if (joy_seen[15:0] === 16'h000F) t_hit = cyc;
    end
    check("multi_seen_found", (t_hit >= 0) ? 64'd1 : 64'd0, 64'd1);
    check("multi_cnt", press_count[3:0], 64'd4);
    check("multi_stable", joy_stable[15:0], 64'h000F);
    check("multi_done_pre", joy_done, 64'd0);
    step(1);
    check("multi_done", joy_done, 64'b01);

    // 20 presses on channel 1 bit 5 saturate the counter
    for (int p = 1; p <= 20; p++) begin
      joy_in[21] = 1'b1;
      step(16);
      joy_in[21] = 1'b0;
      step(16);
      if (p == 10) check("sat_mid", press_count[7:4], 64'd10);
    end
    step(20);
    check("sat_cnt", press_count[7:4], 64'd15);
    check("sat_seen", joy_seen[31:16], 64'h0020);
    check("sat_done", joy_done, 64'b01);
    check("sat_cnt0", press_count[3:0], 64'd4);

    // user button: one toggle per press, release ignored
    btn_user = 1'b1; step(40);
    check("mode_p1", mode, 64'd1);
    btn_user = 1'b0; step(40);
    check("mode_r1", mode, 64'd1);
    btn_user = 1'b1; step(40);
    check("mode_p2", mode, 64'd0);
    btn_user = 1'b0; step(40);
    check("mode_r2", mode, 64'd0);

    // clear coincident with a rise on channel 0 bit 4
    joy_in[4] = 1'b1;
    t_hit = -1;
    for (int k = 0; k < 30 && t_hit < 0; k++) begin
      step(1);
      if (joy_stable[4] === 1'b1) t_hit = cyc;
    end
    check("clr_rise_found", (t_hit >= 0) ? 64'd1 : 64'd0, 64'd1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clr_seen", joy_seen, 64'd0);
    check("clr_cnt", press_count, 64'd0);
    check("clr_done_lag", joy_done, 64'b01);
    check("clr_stable", joy_stable, 64'h0000_001F);
    step(1);
    check("clr_done", joy_done, 64'd0);
    check("clr_seen2", joy_seen, 64'd0);
    check("clr_cnt2", press_count, 64'd0);

    // reset mid-debounce on channel 1 bit 7: restarts from scratch
    joy_in[23] = 1'b1;
    step(9);
    rst = 1'b1;
    step(1);
    check("rst2_stable", joy_stable, 64'd0);
    rst = 1'b0;
    cyc = 0;
    step(13);
    check("rst2_pre", joy_stable, 64'd0);
    step(1);
    check("rst2_stable14", joy_stable, 64'h0080_001F);
    check("rst2_mode", mode, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
